// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM state type and sizing helpers for the SPI transaction arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, DRAIN, GAP} state_e;

    // Outstanding count never exceeds 3; setup/gap counters cover up to 15 cycles.
    localparam int OutW = 2;
    localparam int CntW = 4;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder, scanning upward from ptr_i with wrap.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int W = owner_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] j;

    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        j       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                idx_o   = j;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: grants whole SPI transactions round-robin to NumReq requesters,
// drives one active-low chip select per requester and routes RX bytes to the owner.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int CsSetupCycles  = 1,
    parameter int CsGapCycles    = 2,
    parameter int MaxOutstanding = 2,
    localparam int OwnerW = owner_w(NumReq)
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic [NumReq-1:0]     rsp_valid_o,
    output logic [7:0]            rsp_data_o,
    output logic                  spi_tx_valid_o,
    input  logic                  spi_tx_ready_i,
    output logic [7:0]            spi_tx_data_o,
    input  logic                  spi_rx_valid_i,
    input  logic [7:0]            spi_rx_data_i,
    output logic [NumReq-1:0]     spi_cs_no,
    output logic                  busy_o,
    output logic [OwnerW-1:0]     owner_o
);

    state_e              state_q, state_d;
    logic [OwnerW-1:0]   owner_q, owner_d, ptr_q, ptr_d, pick_idx, ptr_next;
    logic                pick_found;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OutW-1:0]     out_q, out_d;
    logic [NumReq-1:0]   own_oh, rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    logic                can_send, tx_hs, rx_take;

    rr_pick #(.N(NumReq)) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign own_oh         = NumReq'(1) << owner_q;
    assign can_send       = out_q < OutW'(MaxOutstanding);
    assign spi_tx_valid_o = (state_q == XFER) && req_valid_i[owner_q] && can_send;
    assign spi_tx_data_o  = (state_q == XFER) ? req_data_i[owner_q*8 +: 8] : 8'h00;
    assign req_ready_o    = ((state_q == XFER) && spi_tx_ready_i && can_send) ? own_oh : '0;
    assign tx_hs          = spi_tx_valid_o && spi_tx_ready_i;
    // An RX byte with nothing outstanding is stray and is dropped.
    assign rx_take        = spi_rx_valid_i && (out_q != '0);
    assign spi_cs_no      = ~((state_q inside {SETUP, XFER, DRAIN}) ? own_oh : '0);
    assign busy_o         = state_q != IDLE;
    assign owner_o        = owner_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign ptr_next       = (owner_q == OwnerW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_d       = out_q + OutW'(tx_hs) - OutW'(rx_take);
        rsp_valid_d = rx_take ? own_oh : '0;
        rsp_data_d  = rx_take ? spi_rx_data_i : rsp_data_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SETUP;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CntW'(CsSetupCycles - 1)) ? XFER : SETUP;
            end
            XFER:    state_d = (tx_hs && req_last_i[owner_q]) ? DRAIN : XFER;
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    ptr_d   = ptr_next;
                end
            end
            GAP: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CntW'(CsGapCycles - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    cs_onehot: assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni) $onehot0(~spi_cs_no));
    out_bound: assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni) out_q <= OutW'(MaxOutstanding));

endmodule
